// File: rtl/imem_ctrl.sv
`timescale 1ns / 1ps
// Instruction memory controller. It assembles a byte-stream image into
// 32-bit words, writes them into a synchronous-read memory, and then serves
// core instruction fetches with 1-cycle latency until a reload is requested.
module imem_ctrl #(
   parameter int unsigned REG_SIZE       = 32,
   parameter int unsigned MEM_SIZE_IN_KB = 1,
   parameter int unsigned NO_OF_WORDS    = MEM_SIZE_IN_KB * 1024 / 4,
   localparam int unsigned AW            = $clog2(NO_OF_WORDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   // Loader byte stream
   input  logic                ld_valid_i,
   input  logic [7:0]          ld_byte_i,
   input  logic                ld_last_i,
   output logic                ld_ready_o,
   input  logic                reload_i,
   // Core fetch port
   input  logic                fetch_req_i,
   input  logic [REG_SIZE-1:0] fetch_addr_i,
   output logic                fetch_gnt_o,
   output logic                fetch_rvalid_o,
   output logic [REG_SIZE-1:0] fetch_rdata_o,
   output logic                fetch_misalign_o,
   // Status
   output logic                core_en_o,
   output logic                ld_err_o,
   output logic [AW:0]         ld_words_o,
   // Memory port
   output logic                mem_we_o,
   output logic [AW-1:0]       mem_addr_o,
   output logic [REG_SIZE-1:0] mem_wdata_o,
   input  logic [REG_SIZE-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {StLoad, StWrite, StRun, StDrain} state_e;

   localparam logic [AW:0] FullPtr = (AW + 1)'(NO_OF_WORDS);

   state_e              state_q, state_d;
   logic [AW:0]         ptr_q, ptr_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [REG_SIZE-1:0] asm_q, asm_d;
   logic                last_q, last_d;
   logic                err_q, err_d;
   logic [AW:0]         words_q, words_d;
   logic                pend_q, pend_d;
   logic                mis_q, mis_d;
   logic [REG_SIZE-1:0] rdata_q, rdata_d;

   logic byte_acc;
   logic ptr_full;
   logic gnt;

   // Only the word-index bits of the fetch address matter; the rest wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^fetch_addr_i[REG_SIZE-1:AW+2];

   assign byte_acc = (state_q == StLoad) && ld_valid_i;
   assign ptr_full = (ptr_q == FullPtr);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad: begin
            if (byte_acc && ((cnt_q == 2'd3) || ld_last_i)) state_d = StWrite;
         end
         StWrite: state_d = last_q ? StRun : StLoad;
         StRun: begin
            if (reload_i) state_d = pend_q ? StDrain : StLoad;
         end
         StDrain: begin
            if (!pend_q) state_d = StLoad;
         end
         default: state_d = StLoad;
      endcase
   end

   // Output decode; memory port is shared between image writes and fetches
   always_comb begin
      ld_ready_o       = (state_q == StLoad);
      core_en_o        = (state_q == StRun);
      gnt              = (state_q == StRun) && !reload_i && fetch_req_i;
      fetch_gnt_o      = gnt;
      fetch_rvalid_o   = pend_q;
      fetch_rdata_o    = pend_q ? mem_rdata_i : rdata_q;
      fetch_misalign_o = mis_q;
      ld_err_o         = err_q;
      ld_words_o       = words_q;
      mem_we_o         = 1'b0;
      mem_addr_o       = '0;
      mem_wdata_o      = '0;
      if (state_q == StWrite) begin
         mem_we_o    = !ptr_full;
         mem_addr_o  = ptr_q[AW-1:0];
         mem_wdata_o = asm_q;
      end else if (gnt) begin
         mem_addr_o = fetch_addr_i[AW+1:2];
      end
   end

   // Datapath next-state: word assembly, pointer, status and fetch return
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      last_d  = last_q;
      err_d   = err_q;
      words_d = words_q;
      pend_d  = gnt;
      mis_d   = gnt ? (fetch_addr_i[1:0] != 2'b00) : mis_q;
      rdata_d = pend_q ? mem_rdata_i : rdata_q;

      if (byte_acc) begin
         asm_d = asm_q | (REG_SIZE'(ld_byte_i) << {cnt_q, 3'b000});
         cnt_d = cnt_q + 2'd1;
         if (ld_last_i) last_d = 1'b1;
      end

      if (state_q == StWrite) begin
         asm_d  = '0;
         cnt_d  = '0;
         last_d = 1'b0;
         // On overflow the pointer saturates so ld_words_o reports capacity
         if (ptr_full) begin
            err_d = 1'b1;
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
         if (last_q) words_d = ptr_d;
      end

      // Returning to load mode starts a fresh image
      if ((state_q == StRun || state_q == StDrain) && state_d == StLoad) begin
         ptr_d  = '0;
         cnt_d  = '0;
         asm_d  = '0;
         last_d = 1'b0;
         err_d  = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         cnt_q   <= '0;
         asm_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         words_q <= '0;
         pend_q  <= 1'b0;
         mis_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         last_q  <= last_d;
         err_q   <= err_d;
         words_q <= words_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
